mxint_block_quantizer: RTL
==========================

Name: mxint_block_quantizer

Overview:
- Streaming successor to the single-value MXINT8 broadcaster: accepts BLOCK_SIZE float32 values one per beat and computes the shared scale from the maximum exponent.
- Quantises each element to a signed ELEM_WIDTH-bit MXINT element with round-to-nearest-even and saturation.
- Streams the elements out one per beat alongside the held scale.
- Sits between the float32 operand feed and the MX ALU input buffers.

Parameters:
BLOCK_SIZE, 32, elements per MX block (>=2)
ELEM_WIDTH, 8, MXINT element width; format = sign, 1 integer bit, ELEM_WIDTH-2 fraction bits (2 <= ELEM_WIDTH <= 24)

Ports:
i_clk  input  1  clock; all state changes on rising edge
i_rst  input  1  asynchronous, active-high reset
i_valid  input  1  input float32 valid
o_ready  output  1  block can accept input
i_float32  input  32  IEEE-754 binary32 element
o_valid  output  1  output element valid
i_ready  input  1  downstream accepts output element
o_scale  output  8  shared biased scale (E8M0), constant for the whole emitted block
o_element  output  ELEM_WIDTH  two's-complement MXINT element
o_last  output  1  high on the final element beat of a block
o_nan  output  1  block contains NaN/Inf; constant for the whole emitted block

Behaviour:
- Reset values: state=COLLECT, counters=0, max exponent=0, NaN flag=0; o_ready=1, o_valid=0, o_scale=0, o_element=0, o_last=0, o_nan=0.
- Reset asserted mid-block discards all buffered data.
- Two-state FSM.
  - COLLECT: o_ready=1. Each i_valid&&o_ready beat stores i_float32 in buffer[in_cnt], updates max exponent, sets the NaN flag if exponent==0xFF, and increments in_cnt.
  - COLLECT -> EMIT: on the beat accepting in_cnt==BLOCK_SIZE-1. in_cnt wraps to 0.
  - EMIT: o_ready=0, o_valid=1. A beat completes on o_valid&&i_ready; out_cnt increments and o_element/o_last present buffer[out_cnt]. o_last = (out_cnt==BLOCK_SIZE-1).
  - EMIT -> COLLECT: on the final accepted beat. o_ready returns the next cycle; input and output never overlap.
- Latency: first o_valid is the cycle after the last input accept. Full block turnaround = 2*BLOCK_SIZE cycles with no stalls.
- Outputs hold stable while o_valid && !i_ready.
- Registered quantities: o_scale and o_nan are registered when entering EMIT. o_element is combinational from the buffer entry and the registered scale.
- Scale:
  - If the NaN flag is set: o_scale=0xFF, o_nan=1, every element=0.
  - Otherwise o_scale = max biased exponent over the block; an all-zero block gives o_scale=0.
- Element quantisation, input exponent e:
  - e==0 (zero/subnormal): element 0.
  - Otherwise sig = {1, mantissa} (24 bits), shift = o_scale - e.
  - q = sig >> (23-(ELEM_WIDTH-2)+shift), rounded RNE using the guard bit and OR of sticky bits. Shifts >= 25 give q=0.
  - q >= 2^(ELEM_WIDTH-1) saturates to 2^(ELEM_WIDTH-1)-1.
  - Sign applied last by two's complement, so the range is symmetric: most negative = -(2^(ELEM_WIDTH-1)-1).
- Element value = o_element * 2^(o_scale-127) / 2^(ELEM_WIDTH-2).

Optional Feature:
- Macro MXQ_SUBNORMAL_EN.
- Defined: subnormal inputs (e==0, mantissa!=0) use effective exponent 1 and sig={0, mantissa}. They participate in the max exponent (as 1) and quantise normally.
- Undefined: subnormals flush to zero, contribute exponent 0, and produce element 0.

Test Plan:
- BLOCK_SIZE=4, ELEM_WIDTH=8. In 0x3F800000, 0x3F000000, 0xC0000000, 0x00000000 -> o_scale=0x80, elements 0x20, 0x10, 0xC0, 0x00; o_last on 4th beat; first o_valid 1 cycle after 4th accept.
- Rounding, block 0x3F800000, 0x3F810000, 0x3F830000, 0x3FFFFFFF -> o_scale=0x7F, elements 0x40, 0x40 (tie to even), 0x42 (tie up), 0x7F (saturated from 128). Negated inputs -> 0xC0, 0xC0, 0xBE, 0x81.
- NaN, block 0x3F800000, 0x7FC00000, 0x40000000, 0x00000000 -> o_scale=0xFF, o_nan=1, all elements 0x00.
- Backpressure: hold i_ready=0 for 3 cycles on beat 2 -> o_element/o_last stable, no beat lost, o_ready stays 0 until the final beat is accepted.
- Reset asserted after 2 accepted inputs -> all outputs return to reset values immediately. The next 4 inputs form a fresh block, and o_scale reflects only them.
- Subnormal block 0x00400000, 0, 0, 0:
  - With MXQ_SUBNORMAL_EN: o_scale=0x01, elements 0x20, 0, 0, 0.
  - Without: o_scale=0x00, all elements 0x00.

Source files
------------

// File: rtl/mxint_block_quantizer.sv
// mxint_block_quantizer: collects BLOCK_SIZE float32 values, derives a shared E8M0 scale, streams signed MXINT elements.
// Ports: i_clk/i_rst (async active-high) | i_valid/o_ready/i_float32 input stream |
//        o_valid/i_ready/o_element/o_last output stream | o_scale/o_nan held for the whole emitted block.
// Optional: define MXQ_SUBNORMAL_EN to quantise subnormal inputs instead of flushing them to zero.
module mxint_block_quantizer #(
  parameter int BLOCK_SIZE = 32,
  parameter int ELEM_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [31:0]           i_float32,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [7:0]            o_scale,
  output logic [ELEM_WIDTH-1:0] o_element,
  output logic                  o_last,
  output logic                  o_nan
);
  localparam int CW = $clog2(BLOCK_SIZE);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_SIZE - 1);
  localparam logic [24:0] QMAX = 25'((1 << (ELEM_WIDTH - 1)) - 1);
  typedef enum logic {COLLECT, EMIT} state_t;
  state_t r_state;
  logic [31:0] r_buf [BLOCK_SIZE];
  logic [CW-1:0] r_in_cnt, r_out_cnt;
  logic [7:0] r_max_exp, r_scale;
  logic r_nan_flag, r_nan;
  logic [7:0] w_e_in, w_max_in, w_e_eff;
  logic w_nan_in;
  logic [31:0] w_cur;
  logic [23:0] w_sig;
  logic [9:0] w_sh;
  logic [47:0] w_ext;
  logic [24:0] w_q;
  logic [ELEM_WIDTH-1:0] w_mag, w_elem;
  // Exponent used both for the block maximum and for the per-element shift.
  function automatic logic [7:0] eff_exp(input logic [31:0] f);
`ifdef MXQ_SUBNORMAL_EN
    return (f[30:23] == 8'd0 && f[22:0] != 23'd0) ? 8'd1 : f[30:23];
`else
    return f[30:23];
`endif
  endfunction
  assign w_e_in   = eff_exp(i_float32);
  assign w_max_in = w_e_in > r_max_exp ? w_e_in : r_max_exp;
  assign w_nan_in = r_nan_flag | (&i_float32[30:23]);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= COLLECT;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_max_exp  <= '0;
      r_nan_flag <= 1'b0;
      r_scale    <= '0;
      r_nan      <= 1'b0;
    end else if (r_state == COLLECT) begin
      if (i_valid) begin
        r_in_cnt   <= r_in_cnt == LAST ? '0 : r_in_cnt + CW'(1);
        r_max_exp  <= r_in_cnt == LAST ? '0 : w_max_in;
        r_nan_flag <= r_in_cnt == LAST ? 1'b0 : w_nan_in;
        if (r_in_cnt == LAST) begin
          r_scale <= w_nan_in ? 8'hFF : w_max_in;
          r_nan   <= w_nan_in;
          r_state <= EMIT;
        end
      end
    end else if (i_ready) begin
      r_out_cnt <= r_out_cnt == LAST ? '0 : r_out_cnt + CW'(1);
      if (r_out_cnt == LAST) r_state <= COLLECT;
    end
  end
  // Buffer contents need no reset: they are only read while emitting a freshly filled block.
  always_ff @(posedge i_clk) begin
    if (r_state == COLLECT && i_valid) r_buf[r_in_cnt] <= i_float32;
  end
  assign w_cur   = r_buf[r_out_cnt];
  assign w_e_eff = eff_exp(w_cur);
`ifdef MXQ_SUBNORMAL_EN
  assign w_sig = {|w_cur[30:23], w_cur[22:0]};
`else
  assign w_sig = {1'b1, w_cur[22:0]};
`endif
  // Align to the scale, keeping 24 bits below the binary point for guard/sticky; huge shifts fall out as zero.
  assign w_sh   = {2'b0, r_scale} - {2'b0, w_e_eff} + 10'(25 - ELEM_WIDTH);
  assign w_ext  = {w_sig, 24'd0} >> w_sh;
  assign w_q    = {1'b0, w_ext[47:24]} + 25'(w_ext[23] & ((|w_ext[22:0]) | w_ext[24]));
  assign w_mag  = w_q > QMAX ? QMAX[ELEM_WIDTH-1:0] : w_q[ELEM_WIDTH-1:0];
  assign w_elem = (r_nan || w_e_eff == 8'd0) ? '0 : w_cur[31] ? -w_mag : w_mag;
  assign o_ready   = r_state == COLLECT;
  assign o_valid   = r_state == EMIT;
  assign o_scale   = r_scale;
  assign o_nan     = r_nan;
  assign o_element = o_valid ? w_elem : '0;
  assign o_last    = o_valid && r_out_cnt == LAST;
endmodule
